// File: rtl/var_delay_shift.sv
// Runtime-programmable multi-channel delay line with valid tracking and clock-enable stall.
// Optional settle FSM built when VAR_DELAY_SETTLE_EN is defined.
module var_delay_shift #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 1,
    parameter int MAX_DEPTH = 16,
    parameter int RST_DELAY = 1,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_en,
    input  logic [DW-1:0]             i_delay,
    input  logic                      i_delay_load,
    input  logic                      i_valid,
    input  logic [WIDTH*CHANNELS-1:0] i_data,
    output logic                      o_valid,
    output logic [WIDTH*CHANNELS-1:0] o_data,
    output logic [DW-1:0]             o_delay,
    output logic                      o_busy
);
    localparam int BW = WIDTH * CHANNELS;
    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DELAY_RST = DW'(RST_DELAY);
    localparam logic [DW-1:0] DELAY_ONE = DW'(1);

    logic [BW-1:0] stage_data_q  [MAX_DEPTH];
    logic [BW-1:0] stage_data_d  [MAX_DEPTH];
    logic          stage_valid_q [MAX_DEPTH];
    logic          stage_valid_d [MAX_DEPTH];

    logic [DW-1:0] delay_q, delay_d;
    logic [DW-1:0] load_val;
    logic          delay_change;
    logic [AW-1:0] tap_idx;
    logic          tap_valid;

    // Channels travel together as one bus word, so no per-channel logic is needed.
    always_comb begin
        for (int k = 0; k < MAX_DEPTH; k++) begin
            stage_data_d[k]  = stage_data_q[k];
            stage_valid_d[k] = stage_valid_q[k];
        end
        if (i_en) begin
            stage_data_d[0]  = i_data;
            stage_valid_d[0] = i_valid;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                stage_data_d[k]  = stage_data_q[k-1];
                stage_valid_d[k] = stage_valid_q[k-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_data_q[gi]  <= '0;
                    stage_valid_q[gi] <= 1'b0;
                end else begin
                    stage_data_q[gi]  <= stage_data_d[gi];
                    stage_valid_q[gi] <= stage_valid_d[gi];
                end
            end
        end
    endgenerate

    // Requested delay is clamped into 1..MAX_DEPTH before it is compared or applied.
    always_comb begin
        load_val = i_delay;
        if (i_delay == '0) begin
            load_val = DELAY_ONE;
        end else if (i_delay > DEPTH_MAX) begin
            load_val = DEPTH_MAX;
        end
        delay_change = i_delay_load && (load_val != delay_q);
        delay_d      = delay_change ? load_val : delay_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q <= DELAY_RST;
        end else begin
            delay_q <= delay_d;
        end
    end

    assign tap_idx   = AW'(delay_q - DELAY_ONE);
    assign tap_valid = stage_valid_q[tap_idx];
    assign o_data    = stage_data_q[tap_idx];
    assign o_delay   = delay_q;

`ifdef VAR_DELAY_SETTLE_EN
    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // A fresh change restarts the count; otherwise count enabled edges down to 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (delay_change) begin
            state_d = S_SETTLE;
            cnt_d   = load_val;
        end else if (state_q == S_SETTLE && i_en) begin
            if (cnt_q <= DELAY_ONE) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - DELAY_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_busy  = (state_q == S_SETTLE);
    assign o_valid = tap_valid && (state_q != S_SETTLE);
`else
    assign o_busy  = 1'b0;
    assign o_valid = tap_valid;
`endif

endmodule

// File: tb/tb_var_delay_shift.sv
// Scoreboard bench for var_delay_shift: a history-based reference model predicts each cycle's
// outputs, a monitor compares them one cycle-edge later.
module tb_var_delay_shift;
    localparam int W  = 16;
    localparam int CH = 2;
    localparam int MD = 16;
    localparam int RD = 1;
    localparam int DW = $clog2(MD + 1);
    localparam int BW = W * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_en = 1'b0;
    logic [DW-1:0] i_delay = '0;
    logic          i_delay_load = 1'b0;
    logic          i_valid = 1'b0;
    logic [BW-1:0] i_data = '0;
    logic          o_valid;
    logic [BW-1:0] o_data;
    logic [DW-1:0] o_delay;
    logic          o_busy;

    var_delay_shift #(.WIDTH(W), .CHANNELS(CH), .MAX_DEPTH(MD), .RST_DELAY(RD)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_delay(i_delay),
        .i_delay_load(i_delay_load), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_data(o_data), .o_delay(o_delay), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [BW-1:0] d;
        int            dly;
        logic          busy;
    } exp_t;

    exp_t        sb[$];
    logic [BW:0] hist[$];   // {valid,data} accepted on enabled edges, index 0 = newest
    int          m_delay;
    int          m_left;    // enabled edges of settling still to go
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > MD) return MD;
        return d;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < MD; k++) hist.push_back('0);
        m_delay = RD;
        m_left  = 0;
    endtask

    // One clock of stimulus; the expected post-edge outputs are queued for the monitor.
    task automatic step(input logic en, input logic v, input logic [BW-1:0] d,
                        input logic load, input int dly);
        exp_t e;
        int   nd;
        logic changed;
        @(negedge clk);
        i_en         = en;
        i_valid      = v;
        i_data       = d;
        i_delay_load = load;
        i_delay      = load ? DW'(dly) : DW'($urandom);
        if (en) begin
            hist.push_front({v, d});
            void'(hist.pop_back());
        end
        nd      = clampd(dly);
        changed = load && (nd != m_delay);
        if (changed) begin
            m_delay = nd;
            m_left  = nd;
        end else if (en && m_left > 0) begin
            m_left--;
        end
        if (load) $display("load req=%0d applied=%0d changed=%0b", dly, m_delay, changed);
`ifdef VAR_DELAY_SETTLE_EN
        e.busy = (m_left > 0);
`else
        e.busy = 1'b0;
`endif
        e.v   = hist[m_delay-1][BW] && !e.busy;
        e.d   = hist[m_delay-1][BW-1:0];
        e.dly = m_delay;
        sb.push_back(e);
    endtask

    function automatic logic [BW-1:0] ramp(input int k);
        return {16'hA000 + 16'(k), 16'hB000 + 16'(k)};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("o_valid", 64'(o_valid), 64'(e.v));
                chk("o_data",  64'(o_data),  64'(e.d));
                chk("o_delay", 64'(o_delay), 64'(e.dly));
                chk("o_busy",  64'(o_busy),  64'(e.busy));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data",  64'(o_data),  64'd0);
        chk("rst_delay", 64'(o_delay), 64'(RD));
        chk("rst_busy",  64'(o_busy),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("phase ramp at delay 1");
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, ramp(k), 1'b0, 0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, '0, 1'b0, 0);

        $display("phase two-channel ramp at delay 5");
        step(1'b1, 1'b0, '0, 1'b1, 5);
        for (int k = 10; k < 20; k++) step(1'b1, 1'b1, ramp(k), 1'b0, 0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, '0, 1'b0, 0);

        $display("phase stall toggling at delay 4");
        step(1'b1, 1'b0, '0, 1'b1, 4);
        for (int k = 0; k < 24; k++) step(k[0] == 1'b0, 1'b1, ramp(30 + k), 1'b0, 0);

        $display("phase clamping");
        step(1'b1, 1'b1, ramp(60), 1'b1, 0);
        step(1'b1, 1'b1, ramp(61), 1'b1, MD + 3);
        step(1'b0, 1'b1, ramp(62), 1'b1, 31);
        step(1'b1, 1'b1, ramp(63), 1'b1, MD);

        $display("phase delay change 3 -> 6 -> 2 mid-stream");
        step(1'b1, 1'b1, ramp(70), 1'b1, 3);
        for (int k = 71; k < 80; k++) step(1'b1, 1'b1, ramp(k), 1'b0, 0);
        step(1'b1, 1'b1, ramp(80), 1'b1, 6);
        for (int k = 81; k < 84; k++) step(1'b1, 1'b1, ramp(k), 1'b0, 0);
        step(1'b1, 1'b1, ramp(84), 1'b1, 2);
        for (int k = 85; k < 97; k++) step(k % 3 != 0, 1'b1, ramp(k), 1'b0, 0);

        $display("phase random");
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 3) != 0, 1'($urandom), BW'($urandom),
                 $urandom_range(0, 15) == 0, int'($urandom_range(0, 31)));

        $display("phase reset during settle");
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, ramp(200 + k), 1'b0, 0);
        step(1'b1, 1'b1, ramp(210), 1'b1, (m_delay == 7) ? 8 : 7);
        step(1'b1, 1'b1, ramp(211), 1'b0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_data",  64'(o_data),  64'd0);
        chk("mid_rst_delay", 64'(o_delay), 64'(RD));
        chk("mid_rst_busy",  64'(o_busy),  64'd0);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b1, ramp(220 + k), 1'b0, 0);
        step(1'b1, 1'b1, ramp(230), 1'b1, 3);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, ramp(231 + k), 1'b0, 0);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
